// File: rtl/iob_wb_bridge.sv
// IOb native to Wishbone B3 classic master bridge, one access in flight.
// Optional bus watchdog: define IOB_WB_BRIDGE_TIMEOUT_EN.
module iob_wb_bridge #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                error,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                busy
);

  localparam int SEL_W = DATA_W / 8;

  localparam logic [ADDR_W-1:0] ADR_MASK =
    ~ADDR_W'(SEL_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic hit;
  logic tmo;

  assign hit  = wb_ack_i | wb_err_i;
  assign busy = (state_q != IDLE);

`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q;

  assign tmo = &wdog_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (state_q != REQ) begin
      wdog_q <= '0;
    end else if (!hit) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid) state_d = REQ;
      end
      REQ: begin
        if (hit || tmo) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready    <= 1'b0;
      error    <= 1'b0;
      rdata    <= '0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_dat_o <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      ready    <= (state_d == RESP);
      wb_cyc_o <= (state_d == REQ);
      wb_stb_o <= (state_d == REQ);
      if (state_q == IDLE && valid) begin
        wb_adr_o <= address & ADR_MASK;
        wb_sel_o <= (|wstrb) ? wstrb : '1;
        wb_we_o  <= |wstrb;
        wb_dat_o <= wdata;
      end
      // err wins over ack; ack/err win over the watchdog
      if (state_q == REQ) begin
        if (wb_err_i) begin
          error <= 1'b1;
          rdata <= '0;
        end else if (wb_ack_i) begin
          error <= 1'b0;
          rdata <= wb_we_o ? '0 : wb_dat_i;
        end else if (tmo) begin
          error <= 1'b1;
          rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_wb_bridge.sv
// Directed self-checking bench for iob_wb_bridge.
// Timeout case follows IOB_WB_BRIDGE_TIMEOUT_EN.
module tb_iob_wb_bridge;

`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        error;
  logic [15:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        busy;

  int checks;
  int failures;

  iob_wb_bridge #(
    .ADDR_W(16),
    .DATA_W(32),
    .TIMEOUT_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .address(address),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ready(ready),
    .error(error),
    .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o),
    .wb_dat_o(wb_dat_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one access; slave responds after `waits` silent REQ cycles
  task automatic txn(
    input string       tag,
    input logic [15:0] a,
    input logic [31:0] d,
    input logic [3:0]  s,
    input int          waits,
    input logic        ack,
    input logic        err,
    input logic [31:0] sd,
    input logic [15:0] e_adr,
    input logic [3:0]  e_sel,
    input logic        e_we,
    input logic [31:0] e_rd,
    input logic        e_err
  );
    int pulses;
    valid   = 1'b1;
    address = a;
    wdata   = d;
    wstrb   = s;
    step();
    valid = 1'b0;
    chk({tag, ".cyc"}, wb_cyc_o, 1);
    chk({tag, ".stb"}, wb_stb_o, 1);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".adr"}, wb_adr_o, e_adr);
    chk({tag, ".sel"}, wb_sel_o, e_sel);
    chk({tag, ".we"}, wb_we_o, e_we);
    if (e_we) chk({tag, ".dat"}, wb_dat_o, d);
    pulses = 0;
    for (int i = 0; i < waits; i++) begin
      step();
      if (ready) pulses++;
    end
    wb_ack_i = ack;
    wb_err_i = err;
    wb_dat_i = sd;
    step();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (ready) pulses++;
    chk({tag, ".ready"}, ready, 1);
    chk({tag, ".error"}, error, e_err);
    chk({tag, ".rdata"}, rdata, e_rd);
    chk({tag, ".cyc_off"}, wb_cyc_o, 0);
    step();
    if (ready) pulses++;
    chk({tag, ".pulses"}, pulses, 1);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".hold_err"}, error, e_err);
    chk({tag, ".hold_rd"}, rdata, e_rd);
  endtask

  int n;
  int k;
  int nr;
  int pos[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    valid    = 1'b0;
    address  = '0;
    wdata    = '0;
    wstrb    = '0;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    #1;
    chk("rst.ready", ready, 0);
    chk("rst.error", error, 0);
    chk("rst.busy", busy, 0);
    chk("rst.cyc", wb_cyc_o, 0);
    chk("rst.stb", wb_stb_o, 0);
    chk("rst.we", wb_we_o, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.adr", wb_adr_o, 0);
    chk("rst.sel", wb_sel_o, 0);
    chk("rst.dat", wb_dat_o, 0);
    step();
    step();
    rst = 1'b1;
    step();

    txn("rd", 16'h0014, 32'h0, 4'h0, 0,
        1'b1, 1'b0, 32'hDEADBEEF,
        16'h0014, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0);

    txn("wr", 16'h0023, 32'h12345678, 4'h4, 3,
        1'b1, 1'b0, 32'hFFFFFFFF,
        16'h0020, 4'h4, 1'b1, 32'h0, 1'b0);

    txn("err", 16'h0031, 32'h0, 4'h0, 1,
        1'b1, 1'b1, 32'h55AA55AA,
        16'h0030, 4'hF, 1'b0, 32'h0, 1'b1);

    txn("rd2", 16'h0103, 32'h0, 4'h0, 2,
        1'b1, 1'b0, 32'hCAFEF00D,
        16'h0100, 4'hF, 1'b0, 32'hCAFEF00D, 1'b0);

    // silent slave
    valid   = 1'b1;
    address = 16'h0040;
    wstrb   = 4'h0;
    step();
    valid = 1'b0;
    n = 0;
    k = 0;
    nr = 0;
`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
    while (!ready && k < 100) begin
      if (wb_cyc_o) n++;
      step();
      k++;
    end
    chk("tmo.cyc_cycles", n, 16);
    chk("tmo.ready", ready, 1);
    chk("tmo.error", error, 1);
    chk("tmo.rdata", rdata, 0);
    chk("tmo.cyc_off", wb_cyc_o, 0);
    step();
    chk("tmo.idle", busy, 0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc_o) n++;
      if (ready) nr++;
      step();
    end
    chk("hang.cyc_cycles", n, 1000);
    chk("hang.ready", nr, 0);
    chk("hang.busy", busy, 1);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
`endif

    // valid held high, slave always acking
    pos.delete();
    valid    = 1'b1;
    address  = 16'h0008;
    wstrb    = 4'h0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hA5A5A5A5;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (ready) pos.push_back(i);
    end
    valid    = 1'b0;
    wb_ack_i = 1'b0;
    step();
    step();
    chk("b2b.pulses", pos.size(), 4);
    if (pos.size() == 4) begin
      chk("b2b.first", pos[0], 2);
      chk("b2b.gap1", pos[1] - pos[0], 3);
      chk("b2b.gap2", pos[2] - pos[1], 3);
      chk("b2b.gap3", pos[3] - pos[2], 3);
    end
    chk("b2b.rdata", rdata, 32'hA5A5A5A5);
    chk("b2b.idle", busy, 0);

    // reset during the second REQ cycle
    valid   = 1'b1;
    address = 16'h0050;
    wstrb   = 4'h0;
    step();
    valid = 1'b0;
    step();
    chk("rmid.cyc_pre", wb_cyc_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmid.cyc", wb_cyc_o, 0);
    chk("rmid.stb", wb_stb_o, 0);
    chk("rmid.busy", busy, 0);
    chk("rmid.ready", ready, 0);
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ready) nr++;
    end
    chk("rmid.noready", nr, 0);
    rst = 1'b1;
    txn("post", 16'h0064, 32'h0, 4'h0, 0,
        1'b1, 1'b0, 32'h0BADF00D,
        16'h0064, 4'hF, 1'b0, 32'h0BADF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
